// File: rtl/bird_physics.sv
// Bird vertical physics for the VGA renderer: per-frame gravity/flap integration and IDLE/FLY/DEAD game FSM.
// Optional flap debouncing is enabled by defining BIRD_FLAP_DEBOUNCE_EN.
module bird_physics #(
  parameter int SCREEN_H = 480,
  parameter int BIRD_H   = 20,
  parameter int START_Y  = 240,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 8,
  parameter int MAX_FALL = 10
`ifdef BIRD_FLAP_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYC = 250000
`endif
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       flap,
  input  logic       vsync,
  output logic [9:0] y,
  output logic [5:0] vel,
  output logic [1:0] state,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2,
    BAD  = 2'd3
  } state_t;

  localparam logic signed [11:0] FLOOR_Y  = 12'(SCREEN_H - BIRD_H);
  localparam logic signed [11:0] MAX_V    = 12'(MAX_FALL);
  localparam logic signed [11:0] GRAV_V   = 12'(GRAVITY);
  localparam logic signed [11:0] FLAP_V   = -12'(FLAP_VEL);
  localparam logic [9:0]         START_YV = 10'(START_Y);

  state_t st_q, st_d;
  logic [9:0] y_d;
  logic [5:0] vel_d;
  logic flap_s1, flap_s2, flap_lvl, flap_lvl_d, flap_pulse, flap_pend, flap_eff;
  logic vsync_d;
  logic signed [11:0] v_cur, v_sum, v_new, y_new;

  always_ff @(posedge dclk) begin
    if (clr) begin
      flap_s1 <= 1'b0;
      flap_s2 <= 1'b0;
    end else begin
      flap_s1 <= flap;
      flap_s2 <= flap_s1;
    end
  end

`ifdef BIRD_FLAP_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [CW-1:0] db_cnt;
  logic          db_lvl;

  // The debounced level only follows the synced level after it has differed for DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge dclk) begin
    if (clr) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (flap_s2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYC - 1)) begin
      db_lvl <= flap_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign flap_lvl = db_lvl;
`else
  assign flap_lvl = flap_s2;
`endif

  assign flap_pulse = flap_lvl & ~flap_lvl_d;
  assign flap_eff   = flap_pend | flap_pulse;

  // A pulse landing in the tick cycle is consumed by that tick, so the pending flag never outlives a frame.
  always_ff @(posedge dclk) begin
    if (clr) begin
      flap_lvl_d <= 1'b0;
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
      flap_pend  <= 1'b0;
    end else begin
      flap_lvl_d <= flap_lvl;
      vsync_d    <= vsync;
      frame_tick <= vsync_d & ~vsync;
      if (frame_tick)
        flap_pend <= 1'b0;
      else if (flap_pulse)
        flap_pend <= 1'b1;
    end
  end

  always_comb begin
    st_d  = st_q;
    y_d   = y;
    vel_d = vel;
    v_cur = {{6{vel[5]}}, vel};
    v_sum = v_cur + GRAV_V;
    v_new = flap_eff ? FLAP_V : ((v_sum > MAX_V) ? MAX_V : v_sum);
    y_new = $signed({2'b00, y}) + v_new;
    case (st_q)
      IDLE: begin
        y_d   = START_YV;
        vel_d = '0;
        if (frame_tick && flap_eff) begin
          st_d  = FLY;
          y_d   = 10'(START_Y - FLAP_VEL);
          vel_d = FLAP_V[5:0];
        end
      end
      FLY: begin
        if (frame_tick) begin
          if (y_new >= FLOOR_Y) begin
            y_d   = FLOOR_Y[9:0];
            vel_d = '0;
            st_d  = DEAD;
          end else if (y_new < 12'sd0) begin
            y_d   = '0;
            vel_d = '0;
          end else begin
            y_d   = y_new[9:0];
            vel_d = v_new[5:0];
          end
        end
      end
      DEAD: begin
        if (frame_tick && flap_eff) begin
          st_d  = IDLE;
          y_d   = START_YV;
          vel_d = '0;
        end
      end
      default: begin
        st_d  = IDLE;
        y_d   = START_YV;
        vel_d = '0;
      end
    endcase
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      st_q <= IDLE;
      y    <= START_YV;
      vel  <= '0;
    end else begin
      st_q <= st_d;
      y    <= y_d;
      vel  <= vel_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_bird_physics.sv
// Self-checking bench for bird_physics: behavioural game model compared every cycle, plus literal checkpoints.
// Works with or without BIRD_FLAP_DEBOUNCE_EN (debounce length 16 in the bench).
module tb_bird_physics;

  localparam int FRAME = 80;
`ifdef BIRD_FLAP_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int DB  = 16;
`else
  localparam bit DEB = 1'b0;
  localparam int DB  = 0;
`endif
  localparam int PRESS = DEB ? 20 : 3;
  localparam int LEAD  = DEB ? DB + 1 : 1;

  logic       dclk = 1'b0;
  logic       clr = 1'b1;
  logic       flap = 1'b0;
  logic       vsync = 1'b1;
  logic [9:0] y;
  logic [5:0] vel;
  logic [1:0] state;
  logic       frame_tick;

`ifdef BIRD_FLAP_DEBOUNCE_EN
  bird_physics #(.DEBOUNCE_CYC(DB)) dut (
`else
  bird_physics dut (
`endif
    .dclk(dclk), .clr(clr), .flap(flap), .vsync(vsync),
    .y(y), .vel(vel), .state(state), .frame_tick(frame_tick)
  );

  always #5 dclk = ~dclk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int tick_cnt = 0;

  // Behavioural model state (plain integers for the game, sample history for the flap path).
  int m_y = 240, m_vel = 0, m_st = 0, m_run = 0;
  bit m_tick = 0, m_pend = 0, m_s1 = 0, m_s2 = 0, m_db = 0, m_lvl_prev = 0, m_vprev = 1;
  bit m_lvl, m_pulse, m_eff;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task game_step(input bit eff);
    int v, ny;
    case (m_st)
      0: if (eff) begin m_st = 1; m_vel = -8; m_y = 232; end
      1: begin
        v  = eff ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
        ny = m_y + v;
        if (ny >= 460) begin m_y = 460; m_vel = 0; m_st = 2; end
        else if (ny < 0) begin m_y = 0; m_vel = 0; end
        else begin m_y = ny; m_vel = v; end
      end
      default: if (eff) begin m_st = 0; m_y = 240; m_vel = 0; end
    endcase
  endtask

  always @(posedge dclk) begin
    if (clr) begin
      m_y = 240; m_vel = 0; m_st = 0; m_tick = 0; m_pend = 0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_lvl_prev = 0; m_vprev = 1;
    end else begin
      m_lvl   = DEB ? m_db : m_s2;
      m_pulse = m_lvl && !m_lvl_prev;
      m_eff   = m_pend || m_pulse;
      if (m_tick) begin
        game_step(m_eff);
        m_pend = 0;
      end else if (m_pulse) begin
        m_pend = 1;
      end
      m_tick     = m_vprev && !vsync;
      m_vprev    = vsync;
      m_lvl_prev = m_lvl;
      if (m_s2 != m_db) begin
        m_run++;
        if (m_run >= DB) begin m_db = m_s2; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = flap;
    end
  end

  always @(negedge dclk) begin
    if (chk_en) begin
      check_output("y", int'(y), m_y);
      check_output("vel", int'($signed(vel)), m_vel);
      check_output("state", int'(state), m_st);
      check_output("frame_tick", int'(frame_tick), int'(m_tick));
    end
    if (frame_tick) tick_cnt++;
  end

  // One frame of FRAME cycles; vsync falls for the last 4 cycles, flap is high for cycles [fs, fs+fl).
  task automatic apply_stimulus(input int fs, input int fl, input int clr_at);
    for (int c = 0; c < FRAME; c++) begin
      @(posedge dclk); #2;
      vsync = (c >= FRAME - 4) ? 1'b0 : 1'b1;
      flap  = (c >= fs && c < fs + fl);
      clr   = (c == clr_at);
    end
  endtask

  task automatic check_game(input string tag, input int ey, input int ev, input int es);
    check_output({tag, ".y"}, int'(y), ey);
    check_output({tag, ".vel"}, int'($signed(vel)), ev);
    check_output({tag, ".state"}, int'(state), es);
  endtask

  int max_vel;

  initial begin
    @(posedge dclk); #2;
    chk_en = 1'b1;
    repeat (2) @(posedge dclk);
    #2;
    check_game("reset", 240, 0, 0);
    check_output("reset.frame_tick", int'(frame_tick), 0);
    clr = 1'b0;
    tick_cnt = 0;

    repeat (5) apply_stimulus(-100, 0, -1);
    check_game("idle5", 240, 0, 0);
    check_output("tick_count", tick_cnt, 5);

    apply_stimulus(10, PRESS, -1);
    check_game("flap1", 232, -8, 1);
    apply_stimulus(-100, 0, -1);
    check_game("fall1", 225, -7, 1);
    apply_stimulus(-100, 0, -1);
    check_game("fall2", 219, -6, 1);

    repeat (28) apply_stimulus(10, PRESS, -1);
    check_game("ceiling", 0, 0, 1);
    apply_stimulus(10, PRESS, -1);
    check_game("ceiling2", 0, 0, 1);

    max_vel = 0;
    for (int f = 0; f < 70; f++) begin
      apply_stimulus(-100, 0, -1);
      if (int'($signed(vel)) > max_vel) max_vel = int'($signed(vel));
    end
    check_output("terminal_vel", max_vel, 10);
    check_game("dead", 460, 0, 2);
    apply_stimulus(-100, 0, -1);
    check_game("dead_hold", 460, 0, 2);
    apply_stimulus(10, PRESS, -1);
    check_game("revive", 240, 0, 0);

    apply_stimulus(FRAME - 4 - LEAD, LEAD + 2, -1);
    check_game("coincident", 232, -8, 1);
    apply_stimulus(-100, 0, -1);
    check_game("no_dup", 225, -7, 1);

    apply_stimulus(-100, 0, 40);
    check_game("clr_mid", 240, 0, 0);
    apply_stimulus(10, PRESS, -1);
    apply_stimulus(10, PRESS, 70);
    check_game("clr_pend", 240, 0, 0);

    apply_stimulus(10, 10, -1);
    check_output("glitch.state", int'(state), DEB ? 0 : 1);

    for (int f = 0; f < 150; f++) begin
      int fs, fl, ca;
      fs = int'($urandom_range(0, FRAME - 1));
      fl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25));
      ca = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
      apply_stimulus(fs, fl, ca);
    end

    @(posedge dclk); #2;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
